nnet_frame_repacketizer: RTL and testbench



---
 rtl/nnet_pkg.sv | 28 ++
 rtl/nnet_hdr_fifo.sv | 55 +++++
 rtl/nnet_frame_repacketizer.sv | 244 ++++++++++++++++++++++++
 tb/tb_nnet_frame_repacketizer.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nnet_pkg.sv
// Shared types and constants for the nnet frame repacketizer.
// FSM state enums, the "zero means default" constants and the size helper.
package nnet_pkg;

  localparam int DEFAULT_TUSER_W = 128;

  // An SPP register value of zero selects the output frame length as SPP
  localparam logic [15:0] SPP_USE_SIZE = 16'd0;

  // A frame length of zero from the HLS core is treated as one sample
  localparam logic [15:0] SIZE_ZERO = 16'd0;

  typedef enum logic [1:0] {
    IN_IDLE      = 2'd0,
    IN_STREAM    = 2'd1,
    IN_HDR_STALL = 2'd2
  } in_state_t;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_STREAM = 1'b1
  } out_state_t;

  function automatic logic [15:0] fix_size(input logic [15:0] size);
    return (size == SIZE_ZERO) ? 16'd1 : size;
  endfunction

endpackage

// File: rtl/nnet_hdr_fifo.sv
// Header FIFO: holds one tuser header per input frame until the matching
// output frame has finished. A push is accepted while full if a pop
// happens in the same cycle.
module nnet_hdr_fifo
  import nnet_pkg::*;
#(
  parameter int WIDTH = DEFAULT_TUSER_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; clear flushes every stored header
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array, written at the tail pointer
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nnet_frame_repacketizer.sv
// Frame repacketizer between an AXI wrapper and an HLS nnet core.
// Input frames are cut by nnet_size_in and their headers queued; output
// frames are cut by nnet_size_out and split into packets of SPP samples.
// Optional macro NNET_FRAME_ERR_EN enables the header-stall counter err_cnt.
module nnet_frame_repacketizer
  import nnet_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int TUSER_W     = DEFAULT_TUSER_W,
  parameter int HDR_DEPTH   = 4,
  parameter int SR_USER_SPP = 131
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               clear,
  input  logic               set_stb,
  input  logic [7:0]         set_addr,
  input  logic [31:0]        set_data,
  input  logic [15:0]        nnet_size_in,
  input  logic [15:0]        nnet_size_out,
  input  logic [31:0]        i_tdata,
  input  logic [TUSER_W-1:0] i_tuser,
  input  logic               i_tlast,
  input  logic               i_tvalid,
  output logic               i_tready,
  output logic [31:0]        o_tdata,
  output logic [TUSER_W-1:0] o_tuser,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               o_tready,
  output logic [DATA_W-1:0]  m_axis_tdata,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  input  logic [DATA_W-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [15:0]        spp_out,
  output logic [15:0]        err_cnt
);

  logic [1:0]   rst_sync;
  logic         rst_n;
  logic         run;
  logic         unused_inputs;

  in_state_t    in_state, in_next;
  out_state_t   out_state, out_next;

  logic [15:0]  in_cnt, in_size_q, in_size_eff;
  logic         in_first, in_last, in_hs;

  logic [15:0]  frm_cnt, pkt_cnt, out_size_q, spp_q, spp_reg;
  logic [15:0]  out_size_eff, spp_eff;
  logic         out_first, frm_last, pkt_last, out_hs;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [TUSER_W-1:0] fifo_head;

  assign unused_inputs = ^{i_tlast, i_tdata, set_data};

  // Reset asserts at once and releases two clock edges later
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];
  assign run   = rst_n & ~clear;

  nnet_hdr_fifo #(
    .WIDTH (TUSER_W),
    .DEPTH (HDR_DEPTH)
  ) u_hdr_fifo (
    .clk   (ap_clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (fifo_push),
    .wdata (i_tuser),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- input path ----------------
  assign in_first     = (in_state != IN_STREAM);
  assign in_size_eff  = in_first ? fix_size(nnet_size_in) : in_size_q;
  assign in_last      = (in_cnt == in_size_eff - 16'd1);
  assign in_hs        = i_tvalid & i_tready;
  assign m_axis_tdata = i_tdata[DATA_W-1:0];

  // Input FSM state register
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) in_state <= IN_IDLE;
    else        in_state <= in_next;
  end

  // Input FSM next state: a frame start against a full FIFO parks in HDR_STALL
  always_comb begin
    in_next = in_state;
    if (clear) begin
      in_next = IN_IDLE;
    end else begin
      case (in_state)
        IN_IDLE, IN_HDR_STALL: begin
          if (in_hs)
            in_next = in_last ? IN_IDLE : IN_STREAM;
          else if (in_state == IN_IDLE && i_tvalid && fifo_full && !fifo_pop)
            in_next = IN_HDR_STALL;
        end
        IN_STREAM: if (in_hs && in_last) in_next = IN_IDLE;
        default:   in_next = IN_IDLE;
      endcase
    end
  end

  // Input FSM outputs: pass valid/ready through unless the header has no slot
  always_comb begin
    i_tready      = 1'b0;
    m_axis_tvalid = 1'b0;
    if (run && (!in_first || !fifo_full || fifo_pop)) begin
      i_tready      = m_axis_tready;
      m_axis_tvalid = i_tvalid;
    end
    m_axis_tlast = m_axis_tvalid & in_last;
    fifo_push    = in_first & in_hs;
  end

  // Input sample counter; the frame length is latched on the first sample
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt    <= 16'd0;
      in_size_q <= 16'd0;
    end else if (clear) begin
      in_cnt    <= 16'd0;
      in_size_q <= 16'd0;
    end else if (in_hs) begin
      if (in_first) in_size_q <= fix_size(nnet_size_in);
      in_cnt <= in_last ? 16'd0 : in_cnt + 16'd1;
    end
  end

`ifdef NNET_FRAME_ERR_EN
  logic [15:0] err_q;

  // Count entries into header stall, saturating
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 16'd0;
    else if (clear)
      err_q <= 16'd0;
    else if (in_state == IN_IDLE && in_next == IN_HDR_STALL && err_q != 16'hFFFF)
      err_q <= err_q + 16'd1;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 16'd0;
`endif

  // ---------------- output path ----------------
  // SPP settings register
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n)
      spp_reg <= 16'd0;
    else if (set_stb && set_addr == 8'(SR_USER_SPP))
      spp_reg <= set_data[15:0];
  end

  assign out_first    = (out_state == OUT_IDLE);
  assign out_size_eff = out_first ? fix_size(nnet_size_out) : out_size_q;
  assign spp_eff      = !out_first ? spp_q :
                        (spp_reg == SPP_USE_SIZE) ? fix_size(nnet_size_out) : spp_reg;
  assign frm_last     = (frm_cnt == out_size_eff - 16'd1);
  assign pkt_last     = (pkt_cnt == spp_eff - 16'd1);
  assign out_hs       = o_tvalid & o_tready;
  assign spp_out      = spp_eff;
  assign o_tdata      = 32'(s_axis_tdata);
  assign o_tuser      = fifo_head;

  // Output FSM state register
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) out_state <= OUT_IDLE;
    else        out_state <= out_next;
  end

  // Output FSM next state
  always_comb begin
    out_next = out_state;
    if (clear) begin
      out_next = OUT_IDLE;
    end else begin
      case (out_state)
        OUT_IDLE:   if (out_hs) out_next = frm_last ? OUT_IDLE : OUT_STREAM;
        OUT_STREAM: if (out_hs && frm_last) out_next = OUT_IDLE;
        default:    out_next = OUT_IDLE;
      endcase
    end
  end

  // Output FSM outputs: samples only flow while a header is available
  always_comb begin
    s_axis_tready = 1'b0;
    o_tvalid      = 1'b0;
    if (run && !fifo_empty) begin
      s_axis_tready = o_tready;
      o_tvalid      = s_axis_tvalid;
    end
    o_tlast  = o_tvalid & (pkt_last | frm_last);
    fifo_pop = out_hs & frm_last;
  end

  // Frame and packet counters; length and SPP are latched at frame start
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt    <= 16'd0;
      pkt_cnt    <= 16'd0;
      out_size_q <= 16'd0;
      spp_q      <= 16'd0;
    end else if (clear) begin
      frm_cnt    <= 16'd0;
      pkt_cnt    <= 16'd0;
      out_size_q <= 16'd0;
      spp_q      <= 16'd0;
    end else if (out_hs) begin
      if (out_first) begin
        out_size_q <= fix_size(nnet_size_out);
        spp_q      <= spp_eff;
      end
      if (frm_last) begin
        frm_cnt <= 16'd0;
        pkt_cnt <= 16'd0;
      end else if (pkt_last) begin
        frm_cnt <= frm_cnt + 16'd1;
        pkt_cnt <= 16'd0;
      end else begin
        frm_cnt <= frm_cnt + 16'd1;
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_nnet_frame_repacketizer.sv
// Testbench for nnet_frame_repacketizer: scenario tasks with a queue-based
// scoreboard for expected input-side and output-side beats.
module tb_nnet_frame_repacketizer;

  localparam int DATA_W  = 16;
  localparam int TUSER_W = 128;
`ifdef NNET_FRAME_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  typedef struct {
    logic [15:0] data;
    logic        last;
  } m_exp_t;

  typedef struct {
    logic [31:0]        data;
    logic [TUSER_W-1:0] user;
    logic               last;
  } o_exp_t;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               set_stb = 1'b0;
  logic [7:0]         set_addr = 8'd0;
  logic [31:0]        set_data = 32'd0;
  logic [15:0]        nnet_size_in = 16'd4;
  logic [15:0]        nnet_size_out = 16'd2;
  logic [31:0]        i_tdata = 32'd0;
  logic [TUSER_W-1:0] i_tuser = '0;
  logic               i_tlast = 1'b0;
  logic               i_tvalid = 1'b0;
  logic               i_tready;
  logic [31:0]        o_tdata;
  logic [TUSER_W-1:0] o_tuser;
  logic               o_tlast;
  logic               o_tvalid;
  logic               o_tready = 1'b1;
  logic [DATA_W-1:0]  m_axis_tdata;
  logic               m_axis_tlast;
  logic               m_axis_tvalid;
  logic               m_axis_tready = 1'b1;
  logic [DATA_W-1:0]  s_axis_tdata = '0;
  logic               s_axis_tvalid = 1'b0;
  logic               s_axis_tready;
  logic [15:0]        spp_out;
  logic [15:0]        err_cnt;

  int checks = 0;
  int errors = 0;

  m_exp_t m_q[$];
  o_exp_t o_q[$];

  nnet_frame_repacketizer #(
    .DATA_W      (DATA_W),
    .TUSER_W     (TUSER_W),
    .HDR_DEPTH   (4),
    .SR_USER_SPP (131)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .clear         (clear),
    .set_stb       (set_stb),
    .set_addr      (set_addr),
    .set_data      (set_data),
    .nnet_size_in  (nnet_size_in),
    .nnet_size_out (nnet_size_out),
    .i_tdata       (i_tdata),
    .i_tuser       (i_tuser),
    .i_tlast       (i_tlast),
    .i_tvalid      (i_tvalid),
    .i_tready      (i_tready),
    .o_tdata       (o_tdata),
    .o_tuser       (o_tuser),
    .o_tlast       (o_tlast),
    .o_tvalid      (o_tvalid),
    .o_tready      (o_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .spp_out       (spp_out),
    .err_cnt       (err_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [TUSER_W-1:0] hdr(input int n);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(n);
    return {4{w}};
  endfunction

  function automatic logic exp_last(input int k, input int spp, input int size);
    return ((k % spp) == spp - 1) || (k == size - 1);
  endfunction

  task automatic write_spp(input logic [7:0] addr, input logic [15:0] value);
    @(negedge ap_clk);
    set_stb = 1'b1; set_addr = addr; set_data = {16'hDEAD, value};
    @(negedge ap_clk);
    set_stb = 1'b0;
  endtask

  // Present one input beat and wait (bounded) for its handshake
  task automatic send_in(input logic [31:0] d, input logic [TUSER_W-1:0] u,
                         output logic [15:0] od, output logic ol, output bit ok);
    int n;
    n = 0;
    @(negedge ap_clk);
    i_tdata = d; i_tuser = u; i_tvalid = 1'b1;
    #1;
    while (!(i_tready && m_axis_tvalid) && n < 50) begin
      @(negedge ap_clk); #1; n++;
    end
    ok = (n < 50); od = m_axis_tdata; ol = m_axis_tlast;
    @(posedge ap_clk); #1;
    i_tvalid = 1'b0;
  endtask

  // Present one core output beat and wait (bounded) for its handshake
  task automatic recv_out(input logic [15:0] d, output logic [31:0] od,
                          output logic [TUSER_W-1:0] ou, output logic ol, output bit ok);
    int n;
    n = 0;
    @(negedge ap_clk);
    s_axis_tdata = d; s_axis_tvalid = 1'b1; o_tready = 1'b1;
    #1;
    while (!(o_tvalid && s_axis_tready) && n < 50) begin
      @(negedge ap_clk); #1; n++;
    end
    ok = (n < 50); od = o_tdata; ou = o_tuser; ol = o_tlast;
    @(posedge ap_clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    ap_rst_n = 1'b0; i_tvalid = 1'b1; s_axis_tvalid = 1'b1;
    repeat (3) @(negedge ap_clk);
    #1;
    checks++;
    if ({o_tvalid, m_axis_tvalid, o_tlast, m_axis_tlast, i_tready, s_axis_tready} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b expected 000000",
               {o_tvalid, m_axis_tvalid, o_tlast, m_axis_tlast, i_tready, s_axis_tready});
    end
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_err_cnt got %0d expected 0", err_cnt);
    end
    i_tvalid = 1'b0; s_axis_tvalid = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    checks++;
    if (i_tready !== 1'b0) begin
      errors++; $display("[TB] FAIL release_ready_early got %b expected 0", i_tready);
    end
    n = 0;
    while (i_tready !== 1'b1 && n < 10) begin @(negedge ap_clk); #1; n++; end
    checks++;
    if (n >= 10) begin
      errors++; $display("[TB] FAIL release_ready_timeout got %b expected 1", i_tready);
    end
  endtask

  task automatic test_basic;
    logic [15:0] od; logic ol; bit ok; m_exp_t me;
    logic [31:0] qd; logic [TUSER_W-1:0] qu; logic ql; o_exp_t oe;
    nnet_size_in = 16'd4; nnet_size_out = 16'd2;
    write_spp(8'd130, 16'd7);
    #1;
    checks++;
    if (spp_out !== 16'd2) begin
      errors++; $display("[TB] FAIL basic_spp_default got %0d expected 2", spp_out);
    end
    for (int k = 0; k < 8; k++) m_q.push_back('{data: 16'h0100 + 16'(k), last: (k % 4 == 3)});
    for (int k = 0; k < 8; k++) begin
      send_in(32'hABCD_0100 + 32'(k), (k < 4) ? hdr(1) : hdr(2), od, ol, ok);
      me = m_q.pop_front();
      checks++;
      if (!ok || od !== me.data || ol !== me.last) begin
        errors++;
        $display("[TB] FAIL basic_in[%0d] got data=%h last=%b hs=%b expected data=%h last=%b",
                 k, od, ol, ok, me.data, me.last);
      end
    end
    for (int k = 0; k < 4; k++)
      o_q.push_back('{data: 32'h0000_8200 + 32'(k), user: (k < 2) ? hdr(1) : hdr(2), last: (k % 2 == 1)});
    for (int k = 0; k < 4; k++) begin
      recv_out(16'h8200 + 16'(k), qd, qu, ql, ok);
      oe = o_q.pop_front();
      checks++;
      if (!ok || qd !== oe.data || qu !== oe.user || ql !== oe.last) begin
        errors++;
        $display("[TB] FAIL basic_out[%0d] got data=%h user=%h last=%b hs=%b expected data=%h user=%h last=%b",
                 k, qd, qu, ql, ok, oe.data, oe.user, oe.last);
      end
    end
  endtask

  task automatic test_spp_split;
    logic [15:0] od; logic ol; bit ok;
    logic [31:0] qd; logic [TUSER_W-1:0] qu; logic ql; o_exp_t oe;
    nnet_size_in = 16'd1; nnet_size_out = 16'd10;
    write_spp(8'd131, 16'd4);
    #1;
    checks++;
    if (spp_out !== 16'd4) begin
      errors++; $display("[TB] FAIL split_spp_out got %0d expected 4", spp_out);
    end
    send_in(32'h0000_0300, hdr(3), od, ol, ok);
    checks++;
    if (!ok || od !== 16'h0300 || ol !== 1'b1) begin
      errors++; $display("[TB] FAIL split_in got data=%h last=%b hs=%b expected data=0300 last=1", od, ol, ok);
    end
    for (int k = 0; k < 10; k++)
      o_q.push_back('{data: 32'h0000_9300 + 32'(k), user: hdr(3), last: exp_last(k, 4, 10)});
    for (int k = 0; k < 10; k++) begin
      recv_out(16'h9300 + 16'(k), qd, qu, ql, ok);
      oe = o_q.pop_front();
      checks++;
      if (!ok || qd !== oe.data || qu !== oe.user || ql !== oe.last) begin
        errors++;
        $display("[TB] FAIL split_out[%0d] got data=%h user=%h last=%b hs=%b expected data=%h user=%h last=%b",
                 k, qd, qu, ql, ok, oe.data, oe.user, oe.last);
      end
    end
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++; $display("[TB] FAIL split_header_popped got s_axis_tready=%b expected 0", s_axis_tready);
    end
  endtask

  task automatic test_size_zero;
    logic [15:0] od; logic ol; bit ok;
    logic [31:0] qd; logic [TUSER_W-1:0] qu; logic ql; o_exp_t oe;
    nnet_size_in = 16'd0; nnet_size_out = 16'd0;
    write_spp(8'd131, 16'd0);
    #1;
    checks++;
    if (spp_out !== 16'd1) begin
      errors++; $display("[TB] FAIL zero_spp_out got %0d expected 1", spp_out);
    end
    for (int k = 0; k < 2; k++) begin
      send_in(32'h0000_0400 + 32'(k), hdr(4 + k), od, ol, ok);
      checks++;
      if (!ok || od !== 16'h0400 + 16'(k) || ol !== 1'b1) begin
        errors++; $display("[TB] FAIL zero_in[%0d] got data=%h last=%b hs=%b expected last=1", k, od, ol, ok);
      end
    end
    for (int k = 0; k < 2; k++) o_q.push_back('{data: 32'h0000_A400 + 32'(k), user: hdr(4 + k), last: 1'b1});
    for (int k = 0; k < 2; k++) begin
      recv_out(16'hA400 + 16'(k), qd, qu, ql, ok);
      oe = o_q.pop_front();
      checks++;
      if (!ok || qd !== oe.data || qu !== oe.user || ql !== oe.last) begin
        errors++;
        $display("[TB] FAIL zero_out[%0d] got data=%h user=%h last=%b hs=%b expected data=%h user=%h last=%b",
                 k, qd, qu, ql, ok, oe.data, oe.user, oe.last);
      end
    end
  endtask

  task automatic test_spp_midframe;
    logic [15:0] od; logic ol; bit ok;
    logic [31:0] qd; logic [TUSER_W-1:0] qu; logic ql; o_exp_t oe;
    nnet_size_in = 16'd1; nnet_size_out = 16'd10;
    write_spp(8'd131, 16'd5);
    for (int k = 0; k < 2; k++) send_in(32'h0000_0600 + 32'(k), hdr(6 + k), od, ol, ok);
    for (int k = 0; k < 10; k++)
      o_q.push_back('{data: 32'h0000_B600 + 32'(k), user: hdr(6), last: exp_last(k, 5, 10)});
    for (int k = 0; k < 10; k++)
      o_q.push_back('{data: 32'h0000_B700 + 32'(k), user: hdr(7), last: exp_last(k, 3, 10)});
    for (int k = 0; k < 20; k++) begin
      if (k == 2) begin
        write_spp(8'd131, 16'd3);
        #1;
        checks++;
        if (spp_out !== 16'd5) begin
          errors++; $display("[TB] FAIL mid_spp_held got %0d expected 5", spp_out);
        end
      end
      if (k == 10) begin
        #1;
        checks++;
        if (spp_out !== 16'd3) begin
          errors++; $display("[TB] FAIL mid_spp_next got %0d expected 3", spp_out);
        end
      end
      recv_out((k < 10) ? 16'hB600 + 16'(k) : 16'hB700 + 16'(k - 10), qd, qu, ql, ok);
      oe = o_q.pop_front();
      checks++;
      if (!ok || qd !== oe.data || qu !== oe.user || ql !== oe.last) begin
        errors++;
        $display("[TB] FAIL mid_out[%0d] got data=%h user=%h last=%b hs=%b expected data=%h user=%h last=%b",
                 k, qd, qu, ql, ok, oe.data, oe.user, oe.last);
      end
    end
  endtask

  task automatic test_hdr_stall;
    logic [15:0] od; logic ol; bit ok; m_exp_t me;
    logic [31:0] qd; logic [TUSER_W-1:0] qu; logic ql;
    write_spp(8'd131, 16'd0);
    nnet_size_in = 16'd2; nnet_size_out = 16'd1;
    @(negedge ap_clk);
    o_tready = 1'b0;
    for (int k = 0; k < 8; k++) m_q.push_back('{data: 16'h0700 + 16'(k), last: (k % 2 == 1)});
    for (int k = 0; k < 8; k++) begin
      send_in(32'h0000_0700 + 32'(k), hdr(10 + k / 2), od, ol, ok);
      me = m_q.pop_front();
      checks++;
      if (!ok || od !== me.data || ol !== me.last) begin
        errors++;
        $display("[TB] FAIL stall_fill[%0d] got data=%h last=%b hs=%b expected data=%h last=%b",
                 k, od, ol, ok, me.data, me.last);
      end
    end
    @(negedge ap_clk);
    i_tdata = 32'h0000_0500; i_tuser = hdr(14); i_tvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (i_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d] got i_tready=%b m_axis_tvalid=%b expected 0 0", c, i_tready, m_axis_tvalid);
      end
      @(negedge ap_clk);
    end
    checks++;
    if (err_cnt !== 16'(ERR_EN)) begin
      errors++; $display("[TB] FAIL stall_err_cnt got %0d expected %0d", err_cnt, ERR_EN);
    end
    s_axis_tdata = 16'h8500; s_axis_tvalid = 1'b1; o_tready = 1'b1;
    #1;
    checks++;
    if (o_tvalid !== 1'b1 || o_tuser !== hdr(10) || o_tlast !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_pop got valid=%b user=%h last=%b expected valid=1 user=%h last=1",
               o_tvalid, o_tuser, o_tlast, hdr(10));
    end
    checks++;
    if (i_tready !== 1'b1 || m_axis_tdata !== 16'h0500 || m_axis_tlast !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_release got ready=%b data=%h last=%b expected ready=1 data=0500 last=0",
               i_tready, m_axis_tdata, m_axis_tlast);
    end
    @(posedge ap_clk); #1;
    s_axis_tvalid = 1'b0; i_tvalid = 1'b0;
    send_in(32'h0000_0501, hdr(14), od, ol, ok);
    checks++;
    if (!ok || od !== 16'h0501 || ol !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_frame5_end got data=%h last=%b hs=%b expected data=0501 last=1", od, ol, ok);
    end
    recv_out(16'h8501, qd, qu, ql, ok);
    checks++;
    if (!ok || qu !== hdr(11) || ql !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_pop2 got user=%h last=%b hs=%b expected user=%h last=1", qu, ql, ok, hdr(11));
    end
    for (int k = 0; k < 2; k++) begin
      send_in(32'h0000_0600 + 32'(k), hdr(15), od, ol, ok);
      checks++;
      if (!ok || ol !== (k == 1)) begin
        errors++; $display("[TB] FAIL stall_frame6[%0d] got last=%b hs=%b expected last=%b hs=1", k, ol, ok, (k == 1));
      end
    end
    checks++;
    if (err_cnt !== 16'(ERR_EN)) begin
      errors++; $display("[TB] FAIL stall_err_hold got %0d expected %0d", err_cnt, ERR_EN);
    end
    @(negedge ap_clk); clear = 1'b1;
    @(negedge ap_clk); clear = 1'b0;
    #1;
    checks++;
    if (err_cnt !== 16'd0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_flush got err_cnt=%0d s_axis_tready=%b expected 0 0", err_cnt, s_axis_tready);
    end
  endtask

  task automatic test_reset_midframe;
    logic [15:0] od; logic ol; bit ok; int n;
    logic [31:0] qd; logic [TUSER_W-1:0] qu; logic ql;
    nnet_size_in = 16'd4; nnet_size_out = 16'd1;
    for (int k = 0; k < 2; k++) send_in(32'h0000_0900 + 32'(k), hdr(20), od, ol, ok);
    @(negedge ap_clk);
    i_tvalid = 1'b1; i_tdata = 32'h0000_0902; s_axis_tvalid = 1'b1; o_tready = 1'b1;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_tvalid, m_axis_tvalid, o_tlast, m_axis_tlast, i_tready, s_axis_tready} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs got %b expected 000000",
               {o_tvalid, m_axis_tvalid, o_tlast, m_axis_tlast, i_tready, s_axis_tready});
    end
    repeat (2) @(negedge ap_clk);
    i_tvalid = 1'b0; s_axis_tvalid = 1'b0;
    ap_rst_n = 1'b1;
    n = 0;
    #1;
    while (i_tready !== 1'b1 && n < 10) begin @(negedge ap_clk); #1; n++; end
    for (int k = 0; k < 4; k++) begin
      send_in(32'h0000_0A00 + 32'(k), hdr(21), od, ol, ok);
      checks++;
      if (!ok || od !== 16'h0A00 + 16'(k) || ol !== (k == 3)) begin
        errors++;
        $display("[TB] FAIL midreset_in[%0d] got data=%h last=%b hs=%b expected last=%b", k, od, ol, ok, (k == 3));
      end
    end
    recv_out(16'hCA00, qd, qu, ql, ok);
    checks++;
    if (!ok || qu !== hdr(21) || ql !== 1'b1 || qd !== 32'h0000_CA00) begin
      errors++;
      $display("[TB] FAIL midreset_out got data=%h user=%h last=%b hs=%b expected data=0000ca00 user=%h last=1",
               qd, qu, ql, ok, hdr(21));
    end
  endtask

  // Runs every scenario in order and prints the summary
  initial begin
    test_reset();
    test_basic();
    test_spp_split();
    test_size_zero();
    test_spp_midframe();
    test_hdr_stall();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guards against a bench that stops making progress
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at %0t expected completion earlier", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
